mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_AW, default 12, width of the word address presented to the data/instruction RAM.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  fetch request, level, held with if_addr until if_gnt.
REQ-006 if_addr  in  32  fetch byte address, word-aligned.
REQ-007 if_gnt  out  1  one-cycle pulse: fetch issued to RAM this cycle.
REQ-008 if_rdata_vld / if_rdata  out  1 / 32  fetched word, valid one cycle after if_gnt.
REQ-009 ex_rden / ex_wren  in  4 / 4  EX byte read/write enables, single-cycle pulse; nonzero means request.
REQ-010 ex_addr / ex_wrdata / ex_sext  in  32 / 32 / 1  EX byte address, lane-replicated store data, load sign-extend flag.
REQ-011 ex_busy  out  1  EX buffer occupied; upstream SHALL stall while high.
REQ-012 ex_rdata_vld / ex_rdata  out  1 / 32  aligned, extended load result.
REQ-013 err_ovf  out  1  sticky: EX request arrived while ex_busy.
REQ-014 mem_addr  out  MEM_AW  word address = selected addr[MEM_AW+1:2].
REQ-015 mem_rden / mem_wren / mem_wrdata  out  1 / 4 / 32  RAM port controls.
REQ-016 mem_rdata  in  32  RAM read data, synchronous, one-cycle latency.

Function
REQ-017 EX request SHALL be captured into a one-entry buffer (addr, rden, wren, wrdata, sext) on the cycle it is asserted; ex_busy = buffer valid.
REQ-018 EX request with both ex_rden and ex_wren nonzero SHALL be treated as a write; read enables ignored.
REQ-019 EX request while ex_busy SHALL be dropped, buffer unchanged, err_ovf set until reset.
REQ-020 Each cycle at most one RAM access SHALL be issued; candidates: buffered EX request, if_req.
REQ-021 Default priority: buffered EX over IF.
REQ-022 Writes SHALL complete in the issue cycle (mem_wren = buffered wren, no response phase); buffer cleared same edge.
REQ-023 Reads: mem_rden=1 in issue cycle; response FSM states S_IDLE, S_IF_RSP, S_EX_RSP record the owner of the outstanding read.
REQ-024 In S_IF_RSP/S_EX_RSP the returned data SHALL be routed to the owner and a new access MAY be issued the same cycle (back-to-back, 1 access/cycle).
REQ-025 EX read buffer SHALL clear on issue; ex_busy low the cycle after issue.
REQ-026 EX load latency: capture cycle T, earliest issue T+1, ex_rdata_vld at T+2.
REQ-027 ex_rdata alignment: rden 1111 -> word; 0011/1100 -> low/high halfword; 0001/0010/0100/1000 -> byte 0/1/2/3; result right-justified, sign-extended if ex_sext else zero-extended.
REQ-028 Unlisted rden patterns SHALL return the raw word.
REQ-029 mem_rden and mem_wren SHALL be zero in cycles with no issue; mem_addr/mem_wrdata don't-care then.
REQ-030 if_gnt SHALL never assert while if_req is low.

Reset
REQ-031 On rst_n low: FSM to S_IDLE, buffer invalid, err_ovf=0, all outputs 0, asynchronously.
REQ-032 Reset mid-read SHALL discard the outstanding read; no rdata_vld after release for it.
REQ-033 First access possible on the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro MEM_ARB_FAIR_EN defined: when both candidates pending and the previous issued access was EX, IF SHALL win; otherwise EX wins.
REQ-035 Macro undefined: strict EX priority per REQ-021; no last-owner state synthesized.

Verification
REQ-036 if_req=1, if_addr=0x40, mem_rdata=0x00A00093 -> if_gnt pulse, mem_addr=0x10, if_rdata=0x00A00093 next cycle.
REQ-037 EX lb ex_addr=0x103, ex_rden=1000, ex_sext=1, mem_rdata=0x80FF0000 -> ex_rdata=0xFFFFFF80 at T+2; same with ex_sext=0 -> 0x00000080.
REQ-038 EX sh ex_addr=0x22, ex_wren=1100, ex_wrdata=0xBEEFBEEF with if_req=1 -> mem_wren=1100 at T+1, mem_addr=0x08, if_gnt at T+2 (strict), IF never lost.
REQ-039 Two EX requests on consecutive cycles -> second dropped, err_ovf=1, first completes normally.
REQ-040 MEM_ARB_FAIR_EN, continuous if_req plus EX request every 2 cycles -> grants alternate EX/IF; undefined -> EX granted whenever buffered.
REQ-041 rst_n pulsed low during S_EX_RSP -> ex_rdata_vld stays 0, ex_busy=0, next fetch serviced normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between an instruction
// fetch port (IF) and a load/store port (EX).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request (level, held until if_gnt)
//   if_gnt                     fetch issued to the RAM this cycle
//   if_rdata_vld/if_rdata      fetched word, one cycle after if_gnt
//   ex_rden/ex_wren            EX byte enables, single-cycle request pulse
//   ex_addr/ex_wrdata/ex_sext  EX byte address, lane-replicated data, sign flag
//   ex_busy                    EX one-entry buffer occupied
//   ex_rdata_vld/ex_rdata      aligned and extended load result
//   err_ovf                    sticky: EX request arrived while ex_busy
//   mem_addr/mem_rden/mem_wren/mem_wrdata/mem_rdata  RAM port (1-cycle read)
//
// Configuration
//   MEM_ARB_FAIR_EN  when defined, IF wins a tie if the previous issued access
//                    was EX; otherwise buffered EX always beats IF.
module mem_arbiter #(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rdata_vld,
  output logic [31:0]       if_rdata,
  input  logic [3:0]        ex_rden,
  input  logic [3:0]        ex_wren,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wrdata,
  input  logic              ex_sext,
  output logic              ex_busy,
  output logic              ex_rdata_vld,
  output logic [31:0]       ex_rdata,
  output logic              err_ovf,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rden,
  output logic [3:0]        mem_wren,
  output logic [31:0]       mem_wrdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IF_RSP,
    S_EX_RSP
  } state_e;

  state_e              state_q, state_d;
  logic                buf_vld_q, buf_vld_d;
  logic [MEM_AW-1:0]   buf_addr_q, buf_addr_d;
  logic [3:0]          buf_rden_q, buf_rden_d;
  logic [3:0]          buf_wren_q, buf_wren_d;
  logic [31:0]         buf_wrdata_q, buf_wrdata_d;
  logic                buf_sext_q, buf_sext_d;
  logic [3:0]          rsp_rden_q, rsp_rden_d;
  logic                rsp_sext_q, rsp_sext_d;
  logic                ovf_q, ovf_d;
`ifdef MEM_ARB_FAIR_EN
  logic                last_ex_q, last_ex_d;
`endif

  logic ex_req;
  logic issue_ex;
  logic issue_if;

  // Address bits outside the RAM word range are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:MEM_AW+2], if_addr[1:0],
                              ex_addr[31:MEM_AW+2], ex_addr[1:0]};

  assign ex_req = (|ex_rden) | (|ex_wren);

  // Arbitration. Gating with rst_n keeps if_gnt and the RAM strobes low
  // while reset is held even if if_req is high.
  always_comb begin
    issue_ex = buf_vld_q;
    issue_if = if_req & ~buf_vld_q;
`ifdef MEM_ARB_FAIR_EN
    if (buf_vld_q && if_req && last_ex_q) begin
      issue_ex = 1'b0;
      issue_if = 1'b1;
    end
`endif
    issue_ex = issue_ex & rst_n;
    issue_if = issue_if & rst_n;
  end

  // RAM port drive; idle cycles present all zeros.
  always_comb begin
    mem_addr   = '0;
    mem_rden   = 1'b0;
    mem_wren   = '0;
    mem_wrdata = '0;
    if (issue_if) begin
      mem_addr = if_addr[MEM_AW+1:2];
      mem_rden = 1'b1;
    end else if (issue_ex) begin
      mem_addr   = buf_addr_q;
      mem_rden   = (buf_wren_q == 4'b0000);
      mem_wren   = buf_wren_q;
      mem_wrdata = buf_wrdata_q;
    end
  end

  assign if_gnt  = issue_if;
  assign ex_busy = buf_vld_q;
  assign err_ovf = ovf_q;

  function automatic logic [31:0] align_load(input logic [31:0] w,
                                             input logic [3:0]  en,
                                             input logic        sx);
    logic [31:0] r;
    case (en)
      4'b0011: r = {{16{sx & w[15]}}, w[15:0]};
      4'b1100: r = {{16{sx & w[31]}}, w[31:16]};
      4'b0001: r = {{24{sx & w[7]}},  w[7:0]};
      4'b0010: r = {{24{sx & w[15]}}, w[15:8]};
      4'b0100: r = {{24{sx & w[23]}}, w[23:16]};
      4'b1000: r = {{24{sx & w[31]}}, w[31:24]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Read data is routed combinationally from the RAM in the response cycle so
  // a load captured at T returns at T+2.
  always_comb begin
    if_rdata_vld = (state_q == S_IF_RSP);
    ex_rdata_vld = (state_q == S_EX_RSP);
    if_rdata     = if_rdata_vld ? mem_rdata : '0;
    ex_rdata     = ex_rdata_vld ? align_load(mem_rdata, rsp_rden_q, rsp_sext_q) : '0;
  end

  always_comb begin
    state_d      = S_IDLE;
    buf_vld_d    = buf_vld_q & ~issue_ex;
    buf_addr_d   = buf_addr_q;
    buf_rden_d   = buf_rden_q;
    buf_wren_d   = buf_wren_q;
    buf_wrdata_d = buf_wrdata_q;
    buf_sext_d   = buf_sext_q;
    rsp_rden_d   = rsp_rden_q;
    rsp_sext_d   = rsp_sext_q;
    ovf_d        = ovf_q | (ex_req & buf_vld_q);
`ifdef MEM_ARB_FAIR_EN
    last_ex_d    = last_ex_q;
    if (issue_ex || issue_if) begin
      last_ex_d = issue_ex;
    end
`endif

    if (issue_if) begin
      state_d = S_IF_RSP;
    end else if (issue_ex && (buf_wren_q == 4'b0000)) begin
      state_d    = S_EX_RSP;
      rsp_rden_d = buf_rden_q;
      rsp_sext_d = buf_sext_q;
    end

    // Capture only into an empty buffer; a request while busy is dropped even
    // if the buffer drains on this same edge.
    if (ex_req && !buf_vld_q) begin
      buf_vld_d    = 1'b1;
      buf_addr_d   = ex_addr[MEM_AW+1:2];
      buf_wren_d   = ex_wren;
      buf_rden_d   = (ex_wren != 4'b0000) ? 4'b0000 : ex_rden;
      buf_wrdata_d = ex_wrdata;
      buf_sext_d   = ex_sext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      buf_vld_q    <= 1'b0;
      buf_addr_q   <= '0;
      buf_rden_q   <= '0;
      buf_wren_q   <= '0;
      buf_wrdata_q <= '0;
      buf_sext_q   <= 1'b0;
      rsp_rden_q   <= '0;
      rsp_sext_q   <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      last_ex_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      buf_vld_q    <= buf_vld_d;
      buf_addr_q   <= buf_addr_d;
      buf_rden_q   <= buf_rden_d;
      buf_wren_q   <= buf_wren_d;
      buf_wrdata_q <= buf_wrdata_d;
      buf_sext_q   <= buf_sext_d;
      rsp_rden_q   <= rsp_rden_d;
      rsp_sext_q   <= rsp_sext_d;
      ovf_q        <= ovf_d;
`ifdef MEM_ARB_FAIR_EN
      last_ex_q    <= last_ex_d;
`endif
    end
  end

endmodule
